// File: rtl/rlbp_cap_pkg.sv
// Shared register map, bit positions and sizing helpers for the RLBP serial capture block.
package rlbp_cap_pkg;

  localparam logic [3:0] OffData   = 4'h0;
  localparam logic [3:0] OffStatus = 4'h4;
  localparam logic [3:0] OffCtrl   = 4'h8;

  localparam int unsigned StLevelLsb = 0;
  localparam int unsigned StEmptyBit = 8;
  localparam int unsigned StFullBit  = 9;
  localparam int unsigned StOvfBit   = 10;
  localparam int unsigned StIdxLsb   = 12;

  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlIrqEnBit  = 1;
  localparam int unsigned CtrlFlushBit  = 2;
  localparam int unsigned CtrlOvfClrBit = 3;

  typedef struct packed {
    logic irq_en;
    logic enable;
  } ctrl_t;

  // Width of the code-index counter for a given code width (at least one bit).
  function automatic int unsigned code_idx_w(int unsigned code_w);
    return ($clog2(32 / code_w) > 0) ? $clog2(32 / code_w) : 1;
  endfunction

endpackage

// File: rtl/rlbp_cap_fifo.sv
// Synchronous word FIFO; a pop in the same cycle lets a push into a full FIFO succeed.
module rlbp_cap_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic [$clog2(Depth):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level   = wptr_q - rptr_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rlbp_serial_capture.sv
// Deserialises the RLBP bit stream into codes, packs them into 32-bit words and
// exposes the word FIFO through a Wishbone classic slave.
module rlbp_serial_capture
  import rlbp_cap_pkg::*;
#(
  parameter int unsigned CODE_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADR   = 32'h3000_0100
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        ser_data_i,
  input  logic        ser_en_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int unsigned CodesPerWord = 32 / CODE_W;
  localparam int unsigned IdxW         = code_idx_w(CODE_W);
  localparam int unsigned CntW         = $clog2(CODE_W);
  localparam int unsigned LvlW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] LastBit  = CntW'(CODE_W - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(CodesPerWord - 1);

  ctrl_t             ctrl_q;
  logic              ovf_q, irq_q, ack_q;
  logic [31:0]       dat_q;
  logic [CODE_W-1:0] code_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic              code_vld_q;
  logic [31:0]       word_q, word_d, word_ins;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic              hit, req, rd, ctrl_wr, flush, ovf_clr, pop, shift, push, drop;
  logic [3:0]        off;
  logic [31:0]       status, rd_data, fifo_rdata;
  logic [LvlW-1:0]   fifo_level;
  logic              fifo_full, fifo_empty;
  logic              unused_bits;

  assign unused_bits = ^{wbs_dat_i[31:4], wbs_sel_i[3:1]};

  // Bus decode; the ack_q mask turns a held strobe into one transfer every second cycle.
  assign hit     = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign off     = wbs_adr_i[3:0];
  assign req     = wbs_cyc_i & wbs_stb_i & ~ack_q & hit;
  assign rd      = req & ~wbs_we_i;
  assign ctrl_wr = req & wbs_we_i & (off == OffCtrl) & wbs_sel_i[0];
  assign flush   = ctrl_wr & wbs_dat_i[CtrlFlushBit];
  assign ovf_clr = ctrl_wr & wbs_dat_i[CtrlOvfClrBit];
  assign pop     = rd & (off == OffData);

  // A flush in the same cycle as a completing bit discards that bit.
  assign shift   = ctrl_q.enable & ser_en_i & ~flush;

  always_comb begin
    status                    = '0;
    status[StLevelLsb +: 6]   = 6'(fifo_level);
    status[StEmptyBit]        = fifo_empty;
    status[StFullBit]         = fifo_full;
    status[StOvfBit]          = ovf_q;
    status[StIdxLsb +: 2]     = 2'(idx_q);
  end

  always_comb begin
    rd_data = '0;
    case (off)
      OffData:   rd_data = fifo_empty ? 32'h0 : fifo_rdata;
      OffStatus: rd_data = status;
      OffCtrl:   rd_data = 32'(ctrl_q);
      default:   rd_data = '0;
    endcase
  end

  // Packer: a code completed on the previous edge lands in the word this cycle.
  always_comb begin
    word_ins = word_q;
    if (code_vld_q) word_ins[32'(idx_q) * CODE_W +: CODE_W] = code_q;
    push   = 1'b0;
    word_d = word_q;
    idx_d  = idx_q;
    if (flush) begin
      push   = code_vld_q | (idx_q != '0);
      word_d = '0;
      idx_d  = '0;
    end else if (code_vld_q) begin
      if (idx_q == LastIdx) begin
        push   = 1'b1;
        word_d = '0;
        idx_d  = '0;
      end else begin
        word_d = word_ins;
        idx_d  = idx_q + 1'b1;
      end
    end
  end

  assign drop = push & fifo_full & ~pop;

  rlbp_cap_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (32)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .push  (push),
    .pop   (pop),
    .wdata (word_ins),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      ctrl_q <= '0;
      ovf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ack_q <= req;
      dat_q <= rd ? rd_data : 32'h0;
      if (ctrl_wr) ctrl_q <= ctrl_t'(wbs_dat_i[1:0]);
      if (ovf_clr) ovf_q <= 1'b0;
      if (drop)    ovf_q <= 1'b1;
      irq_q <= ctrl_q.irq_en & ~fifo_empty;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      code_q     <= '0;
      bit_cnt_q  <= '0;
      code_vld_q <= 1'b0;
      word_q     <= '0;
      idx_q      <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      if (flush) begin
        bit_cnt_q  <= '0;
        code_vld_q <= 1'b0;
      end else begin
        code_vld_q <= shift && (bit_cnt_q == LastBit);
        if (shift) begin
          code_q    <= {code_q[CODE_W-2:0], ser_data_i};
          bit_cnt_q <= (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + 1'b1;
        end
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_rlbp_serial_capture.sv
// Randomised bench for rlbp_serial_capture against a queue-based model of codes and words.
module tb_rlbp_serial_capture;

  localparam int unsigned CODE_W     = 8;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CPW        = 32 / CODE_W;
  localparam logic [31:0] BASE       = 32'h3000_0100;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ser_data = 1'b0, ser_en = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack, irq;
  logic [31:0] rdat;

  rlbp_serial_capture #(
    .CODE_W     (CODE_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BASE_ADR   (BASE)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .ser_data_i (ser_data),
    .ser_en_i   (ser_en),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [31:0]       mq[$];
  logic [CODE_W-1:0] pend[$];
  bit                m_ovf = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] pack_codes();
    logic [31:0] w = '0;
    for (int i = 0; i < pend.size(); i++) w |= 32'(pend[i]) << (i * CODE_W);
    return w;
  endfunction

  task automatic model_word(input logic [31:0] w);
    if (mq.size() < FIFO_DEPTH) mq.push_back(w);
    else m_ovf = 1;
  endtask

  task automatic model_code(input logic [CODE_W-1:0] c);
    pend.push_back(c);
    if (pend.size() == CPW) begin
      model_word(pack_codes());
      pend.delete();
    end
  endtask

  task automatic model_flush();
    if (pend.size() > 0) begin
      model_word(pack_codes());
      pend.delete();
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s = '0;
    s[5:0]   = 6'(mq.size());
    s[8]     = (mq.size() == 0);
    s[9]     = (mq.size() == FIFO_DEPTH);
    s[10]    = m_ovf;
    s[13:12] = 2'(pend.size());
    return s;
  endfunction

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b);
    ser_en = 1'b1; ser_data = b;
    @(posedge clk); #1;
    ser_en = 1'b0; ser_data = 1'b0;
  endtask

  task automatic send_code(input logic [CODE_W-1:0] c);
    for (int i = CODE_W - 1; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic stream_code(input logic [CODE_W-1:0] c);
    send_code(c);
    model_code(c);
  endtask

  task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
    bit got = 0;
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s; r = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1; r = rdat; end
    end
    cyc = 0; stb = 0; we = 0; sel = 0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL wb_ack_timeout adr=%h: no ack, required ack within 8 cycles", a);
    end
  endtask

  task automatic wb_read(input logic [3:0] o, output logic [31:0] r);
    wb_cycle(BASE + 32'(o), 1'b0, 32'h0, 4'h0, r);
  endtask

  task automatic wb_write(input logic [3:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_cycle(BASE + 32'(o), 1'b1, d, s, r);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b, required 0", ack); end
    n_vec++; if (rdat !== 32'h0) begin n_err++; $display("FAIL reset_dat: got %h, required 0", rdat); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b, required 0", irq); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_read(4'h4, r);
    n_vec++; if (r !== 32'h100) begin n_err++; $display("FAIL reset_status: got %h, required 00000100", r); end
    wb_read(4'h8, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h, required 0", r); end
  endtask

  task automatic test_stream();
    logic [31:0] r, e;
    wb_write(4'h8, 32'h1, 4'h1);
    stream_code(8'hA5); stream_code(8'h3C); stream_code(8'h01); stream_code(8'hFF);
    @(posedge clk); #1;
    wb_read(4'h4, r);
    n_vec++; if (r !== 32'h1) begin n_err++; $display("FAIL stream_level: got %h, required 00000001", r); end
    wb_read(4'h0, r);
    e = mq.pop_front();
    n_vec++; if (r !== 32'hFF01_3CA5 || r !== e) begin
      n_err++; $display("FAIL stream_data: got %h, required ff013ca5 (model %h)", r, e);
    end
    wb_read(4'h4, r);
    n_vec++; if (r !== 32'h100) begin n_err++; $display("FAIL stream_empty: got %h, required 00000100", r); end
  endtask

  task automatic test_gap_and_disable();
    logic [31:0] r, e;
    for (int i = 7; i >= 4; i--) send_bit(1'(8'h5A >> i));
    wb_write(4'h8, 32'h0, 4'h1);
    // Bits offered while disabled must be ignored.
    for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)));
    wb_write(4'h8, 32'h1, 4'h1);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 3; i >= 0; i--) send_bit(1'(8'h5A >> i));
    model_code(8'h5A);
    for (int i = 0; i < 3; i++) stream_code(CODE_W'($urandom));
    @(posedge clk); #1;
    wb_read(4'h4, r);
    e = model_status();
    n_vec++; if (r !== e) begin n_err++; $display("FAIL gap_status: got %h, required %h", r, e); end
    wb_read(4'h0, r);
    e = mq.pop_front();
    n_vec++; if (r !== e || r[7:0] !== 8'h5A) begin
      n_err++; $display("FAIL gap_data: got %h, required %h", r, e);
    end
  endtask

  task automatic test_random_stream();
    logic [31:0] r, e;
    logic [CODE_W-1:0] c;
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < CPW; k++) begin
        c = CODE_W'($urandom);
        for (int i = CODE_W - 1; i >= 0; i--) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1 send_bit(c[i]);
        end
        model_code(c);
      end
    @(posedge clk); #1;
    wb_read(4'h4, r);
    e = model_status();
    n_vec++; if (r !== e) begin n_err++; $display("FAIL rand_status: got %h, required %h", r, e); end
    for (int i = 0; i < 3; i++) begin
      wb_read(4'h0, r);
      e = mq.pop_front();
      n_vec++; if (r !== e) begin n_err++; $display("FAIL rand_data[%0d]: got %h, required %h", i, r, e); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r, e;
    for (int w = 0; w < FIFO_DEPTH + 1; w++)
      for (int k = 0; k < CPW; k++) stream_code(CODE_W'($urandom));
    @(posedge clk); #1;
    wb_read(4'h4, r);
    e = model_status();
    n_vec++; if (r !== e || r !== 32'h608) begin
      n_err++; $display("FAIL ovf_status: got %h, required 00000608 (model %h)", r, e);
    end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL ovf_irq_off: got %b, required 0", irq); end
    wb_write(4'h8, 32'h3, 4'h1);
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL ovf_irq_on: got %b, required 1", irq); end
    wb_write(4'h8, 32'hB, 4'h1);
    m_ovf = 0;
    wb_read(4'h4, r);
    n_vec++; if (r !== 32'h208) begin n_err++; $display("FAIL ovf_clr: got %h, required 00000208", r); end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      wb_read(4'h0, r);
      e = mq.pop_front();
      n_vec++; if (r !== e) begin n_err++; $display("FAIL ovf_data[%0d]: got %h, required %h", i, r, e); end
    end
    wb_read(4'h0, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL empty_pop: got %h, required 0", r); end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_drain: got %b, required 0", irq); end
    wb_write(4'h8, 32'h1, 4'h1);
  endtask

  task automatic test_flush();
    logic [31:0] r, e;
    stream_code(8'h11); stream_code(8'h22);
    @(posedge clk); #1;
    wb_write(4'h8, 32'h5, 4'h1);
    model_flush();
    wb_read(4'h4, r);
    e = model_status();
    n_vec++; if (r !== e || r !== 32'h1) begin
      n_err++; $display("FAIL flush_status: got %h, required 00000001 (model %h)", r, e);
    end
    wb_read(4'h0, r);
    e = mq.pop_front();
    n_vec++; if (r !== 32'h0000_2211 || r !== e) begin
      n_err++; $display("FAIL flush_data: got %h, required 00002211 (model %h)", r, e);
    end
    wb_read(4'h8, r);
    n_vec++; if (r !== 32'h1) begin n_err++; $display("FAIL flush_ctrl_rd: got %h, required 1", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, e;
    logic [CODE_W-1:0] c;
    for (int w = 0; w < FIFO_DEPTH; w++)
      for (int k = 0; k < CPW; k++) stream_code(CODE_W'($urandom));
    for (int k = 0; k < CPW - 1; k++) stream_code(CODE_W'($urandom));
    c = CODE_W'($urandom);
    send_code(c);
    // The pop is sampled on the same edge that pushes the completing word.
    wb_read(4'h0, r);
    e = mq.pop_front();
    model_code(c);
    n_vec++; if (r !== e) begin n_err++; $display("FAIL b2b_pop: got %h, required %h", r, e); end
    wb_read(4'h4, r);
    e = model_status();
    n_vec++; if (r !== e || r !== 32'h208) begin
      n_err++; $display("FAIL b2b_status: got %h, required 00000208 (model %h)", r, e);
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      wb_read(4'h0, r);
      e = mq.pop_front();
      n_vec++; if (r !== e) begin n_err++; $display("FAIL b2b_data[%0d]: got %h, required %h", i, r, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, e;
    wb_write(4'h8, 32'h3, 4'h1);
    for (int k = 0; k < CPW + 1; k++) stream_code(CODE_W'($urandom));
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_rst_irq: got %b, required 1", irq); end
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h4;
    @(posedge clk); #1;
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL pre_rst_ack: got %b, required 1", ack); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b, required 0", ack); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b, required 0", irq); end
    cyc = 0; stb = 0;
    mq.delete(); pend.delete(); m_ovf = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wb_read(4'h4, r);
    n_vec++; if (r !== 32'h100) begin n_err++; $display("FAIL post_rst_status: got %h, required 00000100", r); end
    wb_write(4'h8, 32'h3, 4'h2);
    wb_read(4'h8, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL sel_lane: got %h, required 0", r); end
    wb_write(4'h8, 32'h1, 4'h1);
    for (int k = 0; k < CPW; k++) stream_code(CODE_W'($urandom));
    @(posedge clk); #1;
    wb_read(4'h0, r);
    e = mq.pop_front();
    n_vec++; if (r !== e) begin n_err++; $display("FAIL post_rst_data: got %h, required %h", r, e); end
    wb_read(4'h4, r);
    n_vec++; if (r !== 32'h100) begin n_err++; $display("FAIL post_rst_empty: got %h, required 00000100", r); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gap_and_disable();
    test_random_stream();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
